// File: rtl/add_sched_pkg.sv
// Shared types and helpers for the round-robin adder scheduler.
package add_sched_pkg;

  function automatic int id_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  localparam int SCHED_DATA_W = 16;
  localparam int SCHED_N_REQ  = 4;
  localparam int SCHED_ID_W   = id_width(SCHED_N_REQ);

  // Result entry for the default configuration: DATA_W+1 bit sum tagged with requester index.
  typedef struct packed {
    logic [SCHED_DATA_W:0]   sum;
    logic [SCHED_ID_W-1:0]   id;
  } res_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: searches from ptr upward with wrap, ptr moves past the winner on advance.
module rr_arbiter
  import add_sched_pkg::*;
#(
  parameter  int N_REQ = 4,
  localparam int ID_W  = id_width(N_REQ)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_REQ-1:0] i_req,
  input  logic             i_en,
  input  logic             i_adv,
  output logic [N_REQ-1:0] o_gnt,
  output logic [ID_W-1:0]  o_idx
);

  logic [ID_W-1:0] r_ptr;
  logic [ID_W-1:0] w_cand;
  logic            w_hit;

  // Walk offsets from the far end so the candidate closest to ptr wins last.
  always_comb begin
    w_hit  = 1'b0;
    w_cand = '0;
    o_idx  = '0;
    o_gnt  = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      w_cand = ID_W'((int'(r_ptr) + k) % N_REQ);
      if (i_req[w_cand]) begin
        w_hit = 1'b1;
        o_idx = w_cand;
      end
    end
    if (i_en && w_hit) o_gnt[o_idx] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr <= '0;
    end else if (i_adv) begin
      r_ptr <= (o_idx == ID_W'(N_REQ - 1)) ? '0 : o_idx + 1'b1;
    end
  end

endmodule

// File: rtl/add_rr_sched.sv
// Shares one pipelined adder between N_REQ operand streams; results return in issue order via a FWFT FIFO.
module add_rr_sched
  import add_sched_pkg::*;
#(
  parameter  int DATA_W     = 16,
  parameter  int N_REQ      = 4,
  parameter  int PIPE_LAT   = 2,
  parameter  int FIFO_DEPTH = 4,
  localparam int ID_W       = id_width(N_REQ)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_REQ*DATA_W-1:0] dinp_a,
  input  logic [N_REQ*DATA_W-1:0] dinp_b,
  input  logic [N_REQ-1:0]        valid,
  output logic [N_REQ-1:0]        ready,
  output logic [DATA_W:0]         out,
  output logic [ID_W-1:0]         out_id,
  output logic                    valid_out,
  input  logic                    ready_out,
  output logic                    busy
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH + 1);

  typedef struct packed {
    logic [DATA_W:0]   sum;
    logic [ID_W-1:0]   id;
  } entry_t;

  function automatic logic [DATA_W:0] widen_sum(input logic [DATA_W-1:0] a,
                                                input logic [DATA_W-1:0] b);
    return {1'b0, a} + {1'b0, b};
  endfunction

  logic [CW-1:0]     r_credits;
  logic              w_en;
  logic              w_issue;
  logic              w_pop;
  logic              w_wr;
  logic              w_empty;
  logic [N_REQ-1:0]  w_gnt;
  logic [ID_W-1:0]   w_idx;
  logic [DATA_W-1:0] w_a_arr [N_REQ];
  logic [DATA_W-1:0] w_b_arr [N_REQ];

  // Credits stand for free FIFO slots not yet claimed by in-flight sums, so the pipe never stalls.
  assign w_en    = !rst && (r_credits != '0);
  assign ready   = w_gnt;
  assign w_issue = |(valid & w_gnt);

  rr_arbiter #(.N_REQ(N_REQ)) u_arb (
    .clk   (clk),
    .rst   (rst),
    .i_req (valid),
    .i_en  (w_en),
    .i_adv (w_issue),
    .o_gnt (w_gnt),
    .o_idx (w_idx)
  );

  always_comb begin
    for (int i = 0; i < N_REQ; i++) begin
      w_a_arr[i] = dinp_a[i*DATA_W +: DATA_W];
      w_b_arr[i] = dinp_b[i*DATA_W +: DATA_W];
    end
  end

  // Stage p0: granted operands summed; later stages are plain delay.
  logic [PIPE_LAT-1:0] r_vld_p;
  entry_t              r_res_p [PIPE_LAT];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_vld_p <= '0;
    end else begin
      r_vld_p[0] <= w_issue;
      for (int s = 1; s < PIPE_LAT; s++) r_vld_p[s] <= r_vld_p[s-1];
    end
  end

  always_ff @(posedge clk) begin
    r_res_p[0] <= '{sum: widen_sum(w_a_arr[w_idx], w_b_arr[w_idx]), id: w_idx};
    for (int s = 1; s < PIPE_LAT; s++) r_res_p[s] <= r_res_p[s-1];
  end

  // Result FIFO: written from the last pipe stage, head shown combinationally.
  entry_t         r_mem [FIFO_DEPTH];
  logic [AW:0]    r_wptr;
  logic [AW:0]    r_rptr;

  assign w_wr      = r_vld_p[PIPE_LAT-1];
  assign w_empty   = (r_wptr == r_rptr);
  assign valid_out = !rst && !w_empty;
  assign w_pop     = valid_out && ready_out;
  assign out       = r_mem[r_rptr[AW-1:0]].sum;
  assign out_id    = r_mem[r_rptr[AW-1:0]].id;
  assign busy      = !rst && (r_credits != CW'(FIFO_DEPTH));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_wr)  r_wptr <= r_wptr + 1'b1;
      if (w_pop) r_rptr <= r_rptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wptr[AW-1:0]] <= r_res_p[PIPE_LAT-1];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_credits <= CW'(FIFO_DEPTH);
    end else if (w_issue && !w_pop) begin
      r_credits <= r_credits - 1'b1;
    end else if (!w_issue && w_pop) begin
      r_credits <= r_credits + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (!(w_issue && !w_pop && r_credits == '0));
      assert (!(w_pop && !w_issue && r_credits == CW'(FIFO_DEPTH)));
    end
  end

endmodule

// File: tb/tb_add_rr_sched.sv
// Bench for add_rr_sched: scoreboard of expected sums plus per-scenario checks.
module tb_add_rr_sched;

  localparam int DATA_W     = 16;
  localparam int N_REQ      = 4;
  localparam int ID_W       = 2;
  localparam int PIPE_LAT   = 2;
  localparam int FIFO_DEPTH = 4;

  logic                    clk = 1'b0;
  logic                    rst;
  logic [N_REQ*DATA_W-1:0] dinp_a;
  logic [N_REQ*DATA_W-1:0] dinp_b;
  logic [N_REQ-1:0]        valid;
  logic [N_REQ-1:0]        ready;
  logic [DATA_W:0]         out;
  logic [ID_W-1:0]         out_id;
  logic                    valid_out;
  logic                    ready_out;
  logic                    busy;

  int vectors     = 0;
  int miscompares = 0;

  typedef struct packed {
    logic [ID_W-1:0] id;
    logic [DATA_W:0] sum;
  } exp_t;

  exp_t sb[$];
  int   m_ptr;
  int   m_cred;

  always #5 clk = ~clk;

  add_rr_sched #(
    .DATA_W(DATA_W), .N_REQ(N_REQ), .PIPE_LAT(PIPE_LAT), .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .clk(clk), .rst(rst), .dinp_a(dinp_a), .dinp_b(dinp_b), .valid(valid),
    .ready(ready), .out(out), .out_id(out_id), .valid_out(valid_out),
    .ready_out(ready_out), .busy(busy)
  );

  // Reference model: round-robin pointer, credit count and queue of expected results.
  always @(negedge clk) begin
    logic [N_REQ-1:0] exp_rdy;
    logic [DATA_W:0]  s;
    exp_t             e;
    int               g;
    if (rst) begin
      sb.delete();
      m_ptr  = 0;
      m_cred = FIFO_DEPTH;
    end else begin
      exp_rdy = '0;
      g = -1;
      if (m_cred > 0)
        for (int k = N_REQ - 1; k >= 0; k--)
          if (valid[(m_ptr + k) % N_REQ]) g = (m_ptr + k) % N_REQ;
      if (g >= 0) exp_rdy[g] = 1'b1;
      vectors++;
      if (ready !== exp_rdy) begin
        miscompares++;
        $display("FAIL grant: ready=%b expected %b", ready, exp_rdy);
      end
      vectors++;
      if (busy !== (m_cred != FIFO_DEPTH)) begin
        miscompares++;
        $display("FAIL busy: busy=%b expected %b", busy, (m_cred != FIFO_DEPTH));
      end
      if (valid_out === 1'b1 && ready_out === 1'b1) begin
        vectors++;
        if (sb.size() == 0) begin
          miscompares++;
          $display("FAIL unexpected_result: out=%h id=%0d with nothing outstanding", out, out_id);
        end else begin
          e = sb.pop_front();
          if (out !== e.sum || out_id !== e.id) begin
            miscompares++;
            $display("FAIL result: out=%h id=%0d expected out=%h id=%0d", out, out_id, e.sum, e.id);
          end
        end
        m_cred++;
      end
      if (g >= 0) begin
        s = {1'b0, dinp_a[g*DATA_W +: DATA_W]} + {1'b0, dinp_b[g*DATA_W +: DATA_W]};
        sb.push_back('{id: ID_W'(g), sum: s});
        m_cred--;
        m_ptr = (g + 1) % N_REQ;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input int i, input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b);
    dinp_a[i*DATA_W +: DATA_W] = a;
    dinp_b[i*DATA_W +: DATA_W] = b;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    valid = '0;
    ready_out = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    valid = '0;
    ready_out = 1'b1;
    while (n < 50) begin
      @(negedge clk);
      if (busy === 1'b0 && valid_out === 1'b0) break;
      n++;
    end
    vectors++;
    if (n >= 50) begin
      miscompares++;
      $display("FAIL drain_timeout: busy=%b valid_out=%b after %0d cycles, required idle", busy, valid_out, n);
    end
    vectors++;
    if (sb.size() != 0) begin
      miscompares++;
      $display("FAIL missing_results: %0d outstanding, required 0", sb.size());
    end
    tick();
  endtask

  task automatic test_reset();
    valid = '1;
    ready_out = 1'b1;
    @(negedge clk);
    vectors++;
    if (ready !== '0 || valid_out !== 1'b0 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_hold: ready=%b valid_out=%b busy=%b required 0/0/0", ready, valid_out, busy);
    end
    tick();
    rst = 1'b0;
    valid = '0;
    @(negedge clk);
    vectors++;
    if (valid_out !== 1'b0 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_state: valid_out=%b busy=%b required 0/0", valid_out, busy);
    end
    tick();
  endtask

  task automatic test_single();
    do_reset();
    set_op(0, 16'd1, 16'd2);
    valid = 4'b0001;
    ready_out = 1'b1;
    @(negedge clk);
    vectors++;
    if (ready !== 4'b0001) begin
      miscompares++;
      $display("FAIL single_ready: ready=%b required 0001", ready);
    end
    for (int c = 0; c < 2; c++) begin
      tick();
      @(negedge clk);
      vectors++;
      if (valid_out !== 1'b0) begin
        miscompares++;
        $display("FAIL single_latency: valid_out=%b at cycle %0d required 0", valid_out, c);
      end
    end
    for (int c = 0; c < 4; c++) begin
      tick();
      @(negedge clk);
      vectors++;
      if (valid_out !== 1'b1 || out !== 17'd3 || out_id !== 2'd0) begin
        miscompares++;
        $display("FAIL single_result: valid_out=%b out=%h id=%0d required 1/3/0", valid_out, out, out_id);
      end
    end
    tick();
    drain();
  endtask

  task automatic test_all_valid();
    int k;
    int g;
    int cyc;
    do_reset();
    for (int i = 0; i < N_REQ; i++) set_op(i, DATA_W'(i), 16'd10);
    valid = '1;
    k = 0;
    g = 0;
    cyc = 0;
    while (k < 8 && cyc < 40) begin
      @(negedge clk);
      if (|ready && g < 8) begin
        vectors++;
        if (ready !== N_REQ'(1 << (g % 4))) begin
          miscompares++;
          $display("FAIL rr_order: ready=%b at grant %0d", ready, g);
        end
        g++;
      end
      if (valid_out === 1'b1) begin
        vectors++;
        if (out_id !== ID_W'(k % 4) || out !== 17'(10 + k % 4)) begin
          miscompares++;
          $display("FAIL rr_result: out=%h id=%0d required out=%h id=%0d", out, out_id, 17'(10 + k % 4), k % 4);
        end
        k++;
      end
      cyc++;
      tick();
    end
    vectors++;
    if (k < 8) begin
      miscompares++;
      $display("FAIL rr_timeout: %0d results seen, required 8", k);
    end
    drain();
  endtask

  task automatic test_overflow();
    int k;
    int cyc;
    logic [DATA_W:0] exp_sum [2];
    logic [ID_W-1:0] exp_id  [2];
    exp_sum[0] = 17'h1FFFE; exp_id[0] = 2'd0;
    exp_sum[1] = 17'h10000; exp_id[1] = 2'd2;
    do_reset();
    set_op(0, 16'hFFFF, 16'hFFFF);
    set_op(2, 16'hFFFF, 16'h0001);
    valid = 4'b0101;
    k = 0;
    cyc = 0;
    while (k < 2 && cyc < 20) begin
      @(negedge clk);
      if (valid_out === 1'b1) begin
        vectors++;
        if (out !== exp_sum[k] || out_id !== exp_id[k]) begin
          miscompares++;
          $display("FAIL carry: out=%h id=%0d required out=%h id=%0d", out, out_id, exp_sum[k], exp_id[k]);
        end
        k++;
      end
      cyc++;
      tick();
    end
    vectors++;
    if (k < 2) begin
      miscompares++;
      $display("FAIL carry_timeout: %0d results seen, required 2", k);
    end
    drain();
  endtask

  task automatic test_back_to_back();
    int acc;
    do_reset();
    ready_out = 1'b0;
    for (int i = 0; i < N_REQ; i++) set_op(i, DATA_W'(100 + i), DATA_W'(i));
    valid = '1;
    acc = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (|ready) acc++;
      tick();
    end
    @(negedge clk);
    vectors++;
    if (acc !== FIFO_DEPTH || ready !== '0 || busy !== 1'b1 || valid_out !== 1'b1) begin
      miscompares++;
      $display("FAIL full_stall: accepts=%0d ready=%b busy=%b valid_out=%b required 4/0000/1/1",
               acc, ready, busy, valid_out);
    end
    tick();
    ready_out = 1'b1;
    @(negedge clk);
    vectors++;
    if (ready !== '0 || valid_out !== 1'b1 || out_id !== 2'd0 || out !== 17'd100) begin
      miscompares++;
      $display("FAIL first_pop: ready=%b valid_out=%b out=%h id=%0d required 0000/1/100/0",
               ready, valid_out, out, out_id);
    end
    for (int k = 1; k < 4; k++) begin
      tick();
      @(negedge clk);
      if (k == 1) begin
        vectors++;
        if (ready !== 4'b0001) begin
          miscompares++;
          $display("FAIL resume: ready=%b required 0001", ready);
        end
      end
      vectors++;
      if (valid_out !== 1'b1 || out_id !== ID_W'(k) || out !== 17'(100 + 2 * k)) begin
        miscompares++;
        $display("FAIL pop_order: valid_out=%b out=%h id=%0d required 1/%h/%0d",
                 valid_out, out, out_id, 17'(100 + 2 * k), k);
      end
    end
    tick();
    drain();
  endtask

  task automatic test_sparse();
    int g;
    int cyc;
    logic [N_REQ-1:0] exp_g;
    do_reset();
    set_op(1, 16'd5, 16'd6);
    set_op(3, 16'd7, 16'd8);
    valid = 4'b1010;
    g = 0;
    cyc = 0;
    while (g < 4 && cyc < 12) begin
      @(negedge clk);
      vectors++;
      if ((ready & 4'b0101) !== 4'b0000) begin
        miscompares++;
        $display("FAIL sparse_idle: ready=%b, requesters 0 and 2 must stay 0", ready);
      end
      if (|ready) begin
        exp_g = (g % 2 == 0) ? 4'b0010 : 4'b1000;
        vectors++;
        if (ready !== exp_g) begin
          miscompares++;
          $display("FAIL sparse_grant: ready=%b required %b", ready, exp_g);
        end
        g++;
      end
      cyc++;
      tick();
    end
    vectors++;
    if (g < 4) begin
      miscompares++;
      $display("FAIL sparse_timeout: %0d grants seen, required 4", g);
    end
    drain();
  endtask

  task automatic test_reset_midflight();
    int cyc;
    logic seen;
    do_reset();
    ready_out = 1'b0;
    for (int i = 0; i < N_REQ; i++) set_op(i, DATA_W'(200 + i), 16'd1);
    valid = '1;
    tick();
    tick();
    tick();
    rst = 1'b1;
    @(negedge clk);
    vectors++;
    if (ready !== '0 || valid_out !== 1'b0 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL midreset_hold: ready=%b valid_out=%b busy=%b required 0/0/0", ready, valid_out, busy);
    end
    tick();
    rst = 1'b0;
    ready_out = 1'b1;
    @(negedge clk);
    vectors++;
    if (valid_out !== 1'b0 || busy !== 1'b0 || ready !== 4'b0001) begin
      miscompares++;
      $display("FAIL midreset_after: valid_out=%b busy=%b ready=%b required 0/0/0001", valid_out, busy, ready);
    end
    seen = 1'b0;
    cyc = 0;
    while (!seen && cyc < 10) begin
      tick();
      @(negedge clk);
      if (valid_out === 1'b1) begin
        seen = 1'b1;
        vectors++;
        if (out_id !== 2'd0 || out !== 17'd201) begin
          miscompares++;
          $display("FAIL midreset_first: out=%h id=%0d required 201/0", out, out_id);
        end
      end
      cyc++;
    end
    vectors++;
    if (!seen) begin
      miscompares++;
      $display("FAIL midreset_timeout: no result after reset");
    end
    tick();
    drain();
  endtask

  initial begin
    rst = 1'b1;
    valid = '0;
    ready_out = 1'b1;
    dinp_a = '0;
    dinp_b = '0;
    test_reset();
    test_single();
    test_all_valid();
    test_overflow();
    test_back_to_back();
    test_sparse();
    test_reset_midflight();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

endmodule
